// File: rtl/shared_pkg.sv
// Shared types and defaults for the burst SPI-RAM slave: FSM states,
// command codes and default geometry.
package shared_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WRITE,
      READ,
      IGNORE
   } spi_burst_state_e;

   localparam logic [1:0] CMD_WR = 2'b00;
   localparam logic [1:0] CMD_RD = 2'b01;

   localparam int DEF_MEM_WIDTH = 8;
   localparam int DEF_MEM_DEPTH = 256;
   localparam int DEF_ADDR_SIZE = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Word-wide register array: one synchronous write port, one combinational
// read port, intentionally without reset.
module spi_ram_mem
   import shared_pkg::*;
#(
   parameter int MEM_WIDTH = DEF_MEM_WIDTH,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_SIZE-1:0] wr_addr,
   input  logic [MEM_WIDTH-1:0] wr_data,
   input  logic [ADDR_SIZE-1:0] rd_addr,
   output logic [MEM_WIDTH-1:0] rd_data
);

   logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_ram_burst_slave.sv
// SPI slave with burst read/write into an on-chip RAM; address auto-increments
// and wraps at MEM_DEPTH.
//
// state  | meaning
// IDLE   | SS_n high, waiting for frame start
// CMD    | shifting the 2-bit command
// ADDR   | shifting the start address
// WRITE  | shifting in data words, committing each complete word
// READ   | streaming words out on MISO, MOSI ignored
// IGNORE | bad command or address, discard until SS_n high
module spi_ram_burst_slave
   import shared_pkg::*;
#(
   parameter int MEM_WIDTH = DEF_MEM_WIDTH,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic busy,
   output logic err
);

   localparam int CNT_W   = $clog2(max_int(MEM_WIDTH, ADDR_SIZE)) + 1;
   localparam int RX_BITS = max_int(MEM_WIDTH, ADDR_SIZE) - 1;

   localparam logic [CNT_W-1:0]     CMD_LAST  = CNT_W'(1);
   localparam logic [CNT_W-1:0]     ADDR_LAST = CNT_W'(ADDR_SIZE - 1);
   localparam logic [CNT_W-1:0]     WORD_LAST = CNT_W'(MEM_WIDTH - 1);
   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
   localparam logic [ADDR_SIZE:0]   DEPTH_L   = (ADDR_SIZE + 1)'(MEM_DEPTH);

   spi_burst_state_e     state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [RX_BITS-1:0]   rx_shift;
   logic [MEM_WIDTH-1:0] tx_shift;
   logic [ADDR_SIZE-1:0] addr_q;
   logic                 is_rd;

   logic [RX_BITS-1:0]   rx_next;
   logic [ADDR_SIZE-1:0] addr_in;
   logic [MEM_WIDTH-1:0] word_in;
   logic [1:0]           cmd_in;
   logic                 addr_ok;
   logic                 mem_we;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic [MEM_WIDTH-1:0] rd_data;

   function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + 1'b1;
   endfunction

   // Field values include the bit being sampled on this edge.
   assign rx_next = RX_BITS'({rx_shift, MOSI});
   assign addr_in = ADDR_SIZE'({rx_shift, MOSI});
   assign word_in = MEM_WIDTH'({rx_shift, MOSI});
   assign cmd_in  = {rx_shift[0], MOSI};
   assign addr_ok = ({1'b0, addr_in} < DEPTH_L);
   assign mem_we  = (state == WRITE) && !SS_n && (bit_cnt == WORD_LAST);
   assign rd_addr = (state == ADDR) ? addr_in : addr_q;
   assign MISO    = tx_shift[MEM_WIDTH-1];

   spi_ram_mem #(
      .MEM_WIDTH (MEM_WIDTH),
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we),
      .wr_addr (addr_q),
      .wr_data (word_in),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         addr_q   <= '0;
         is_rd    <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         if (SS_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            tx_shift <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state   <= CMD;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
               end
               CMD: begin
                  rx_shift <= rx_next;
                  if (bit_cnt == CMD_LAST) begin
                     bit_cnt <= '0;
                     if (cmd_in == CMD_WR || cmd_in == CMD_RD) begin
                        is_rd <= (cmd_in == CMD_RD);
                        state <= ADDR;
                     end else begin
                        err   <= 1'b1;
                        state <= IGNORE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ADDR: begin
                  rx_shift <= rx_next;
                  if (bit_cnt == ADDR_LAST) begin
                     bit_cnt <= '0;
                     if (!addr_ok) begin
                        err   <= 1'b1;
                        state <= IGNORE;
                     end else if (is_rd) begin
                        // First word is fetched on the last address edge so
                        // its MSB drives MISO with no gap cycle.
                        tx_shift <= rd_data;
                        addr_q   <= next_addr(addr_in);
                        state    <= READ;
                     end else begin
                        addr_q <= addr_in;
                        state  <= WRITE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               WRITE: begin
                  rx_shift <= rx_next;
                  if (bit_cnt == WORD_LAST) begin
                     bit_cnt <= '0;
                     addr_q  <= next_addr(addr_q);
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               READ: begin
                  if (bit_cnt == WORD_LAST) begin
                     bit_cnt  <= '0;
                     tx_shift <= rd_data;
                     addr_q   <= next_addr(addr_q);
                  end else begin
                     bit_cnt  <= bit_cnt + 1'b1;
                     tx_shift <= tx_shift << 1;
                  end
               end
               IGNORE: begin
                  state <= IGNORE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/spi_ram_burst_slave.md
# spi_ram_burst_slave

Parametrised SPI slave with on-chip RAM and burst access. It is the next generation of the single-word SPI-RAM slave and shares its SPI sampling scheme. The block decodes a 2-bit command and an address from MOSI, then streams any number of consecutive words in or out while SS_n stays low. The address auto-increments and wraps at MEM_DEPTH. It sits between the external SPI pins and the rest of the design.

## Interface
- MEM_WIDTH, 8, data word width in bits (≥2)
- MEM_DEPTH, 256, number of words; need not be a power of 2
- ADDR_SIZE, 8, address field width; must satisfy 2**ADDR_SIZE ≥ MEM_DEPTH
- clk  input  1  system clock; all SPI sampling on rising edge
- rst_n  input  1  asynchronous, active-low reset
- SS_n  input  1  slave select, active low, synchronous to clk
- MOSI  input  1  serial data in, MSB first
- MISO  output  1  serial data out, MSB first, registered
- busy  output  1  high whenever state ≠ IDLE, registered
- err  output  1  one-cycle pulse on reserved command or out-of-range address

## Operation
- States: IDLE, CMD, ADDR, WRITE, READ, IGNORE.
- IDLE → CMD on the edge where SS_n is sampled low. That edge does not sample a data bit.
- CMD: 2 bits are sampled.
  - 00 = burst write → ADDR.
  - 01 = burst read → ADDR.
  - 1x = reserved → err pulse, then IGNORE.
- ADDR: ADDR_SIZE bits are sampled.
  - Address ≥ MEM_DEPTH → err pulse, then IGNORE.
  - Otherwise the address is loaded into addr_q and the state moves to WRITE or READ per the command.
- WRITE:
  - MEM_WIDTH bits are shifted in.
  - On the edge that samples the last bit: mem[addr_q] ← word, and addr_q ← (addr_q == MEM_DEPTH-1) ? 0 : addr_q+1.
  - The state stays in WRITE.
- READ:
  - On the edge that samples the last address bit, tx_shift ← mem[addr], and addr_q is incremented with wrap.
  - Each following edge shifts tx_shift left by one.
  - Every MEM_WIDTH edges, tx_shift reloads from mem[addr_q] and addr_q is incremented with wrap. The stream has no gap bits.
  - MOSI is ignored.
- IGNORE: all MOSI is discarded until SS_n goes high.
- SS_n sampled high in any state → IDLE on that edge.
  - A partially shifted write word is discarded; the memory is not modified.
  - A partially shifted read word is abandoned.
- The memory array is not reset. Contents are undefined until written.
- A frame that ends after the command or address field has no side effect.

## Timing
- Reset values: MISO=0, busy=0, err=0, state=IDLE, addr_q=0, shift registers=0.
- MISO = tx_shift[MSB], registered. It is 0 in every state except READ.
- In READ, the first data MSB appears after the same edge that samples the last address bit. It is valid for the whole next cycle.
- Write latency: a word is readable from the cycle after the edge that samples its last bit.
- err is high for exactly one cycle, following the edge that detects the condition.
- busy rises after the edge that samples SS_n low. It falls after the edge that samples SS_n high.
- Reset asserted mid-frame returns to IDLE immediately. The memory keeps its contents.
- An SS_n glitch of one high cycle aborts the frame. The next low starts a new CMD phase.

## Structure
- shared_pkg holds:
  - the state enum (spi_burst_state_e);
  - the command codes CMD_WR=2'b00 and CMD_RD=2'b01;
  - default MEM_WIDTH, MEM_DEPTH and ADDR_SIZE.
- Sub-module spi_ram_mem:
  - register array of MEM_DEPTH × MEM_WIDTH;
  - one synchronous write port;
  - one asynchronous read port;
  - no reset.
- The top level holds the FSM, bit counter ($clog2(max(MEM_WIDTH, ADDR_SIZE))+1 bits), address counter and the rx/tx shift registers.

## Test plan
Parameters for all scenarios: MEM_WIDTH=8, MEM_DEPTH=12, ADDR_SIZE=4.
- Burst write 0xA1, 0xB2, 0xC3 from addr 4, then burst read of 3 words from 4 → MISO streams A1 B2 C3 back-to-back, first MSB the cycle after the last address bit.
- Write burst from addr 11 with 0x11, 0x22 → mem[11]=0x11, mem[0]=0x22 (wrap at MEM_DEPTH). A read from 11 of 2 words returns 11 22.
- Command 2'b10 → err pulses 1 cycle, MISO stays 0, memory unchanged, busy stays high until SS_n high.
- Address 4'd13 → err pulses, nothing written.
- Write frame aborted after 5 of 8 data bits → target word retains its previous value; busy falls the cycle after SS_n high.
- rst_n pulsed low mid-read → MISO, busy and err are 0 immediately; a subsequent read returns the pre-reset memory contents.
